// File: rtl/shift_sequencer_if.sv
// Control-side handshake between the ALU control unit and the shift sequencer.
// master: control unit issuing requests; slave: the sequencer serving them.
interface shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
);
  logic             start;
  logic [WIDTH-1:0] operand;
  logic [CNTW-1:0]  amount;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, operand, amount,
    input  busy, done, result
  );

  modport slave (
    input  start, operand, amount,
    output busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-bit arithmetic right-shift controller for a single-step shifter.
// Loads the operand into the external shifter, clocks it through N
// single-bit arithmetic right shifts by feeding its output back, then
// registers the final value and pulses done.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus,
  output logic [1:0]        sh_s,
  output logic [WIDTH-1:0]  sh_din,
  input  logic [WIDTH-1:0]  sh_dout,
  output logic              sh_rst
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_LOAD  = 2'b00;
  localparam logic [1:0] SEL_SHIFT = 2'b01;

  state_t           state;
  logic [WIDTH-1:0] op_q;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] result_q;
  logic             done_q;

  // Sequencer FSM: accept in IDLE, load, count down shifts, capture result.
  // Requests arriving outside IDLE are dropped; op_q/cnt stay untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      op_q     <= '0;
      cnt      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q  <= bus.operand;
            cnt   <= bus.amount;
            state <= LOAD;
          end
        end
        LOAD: begin
          // Zero-amount requests skip SHIFT entirely.
          state <= (cnt != '0) ? SHIFT : DONE;
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNTW'(1)) state <= DONE;
        end
        DONE: begin
          // Shifter is holding the final value here.
          result_q <= sh_dout;
          done_q   <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shifter drive: load op_q in LOAD, shift in SHIFT, otherwise recirculate
  // the shifter output so it holds its contents.
  always_comb begin
    sh_s   = SEL_LOAD;
    sh_din = sh_dout;
    case (state)
      LOAD:    sh_din = op_q;
      SHIFT:   sh_s   = SEL_SHIFT;
      default: ;
    endcase
  end

  // The shifter reset is synchronous active-high; mirror our reset so it
  // clears on every edge while reset is held.
  assign sh_rst = ~rst;

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural single-step shifter, table-driven
// operations through a scoreboard, plus multi-cycle corner sequences.
module tb_shift_sequencer;
  localparam int WIDTH = 16;
  localparam int CNTW  = 4;

  logic             clk;
  logic             rst;
  logic [1:0]       sh_s;
  logic [WIDTH-1:0] sh_din;
  logic [WIDTH-1:0] sh_dout;
  logic             sh_rst;

  shift_sequencer_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .sh_s   (sh_s),
    .sh_din (sh_din),
    .sh_dout(sh_dout),
    .sh_rst (sh_rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-step shifter: sync active-high reset, 00 load, 01 arith right.
  always @(posedge clk) begin
    if (sh_rst)             sh_dout <= '0;
    else if (sh_s == 2'b00) sh_dout <= sh_din;
    else if (sh_s == 2'b01) sh_dout <= {sh_din[WIDTH-1], sh_din[WIDTH-1:1]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;
  int done_cnt = 0;
  int exp_done = 0;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [WIDTH-1:0] op;
    logic [CNTW-1:0]  amt;
    logic [WIDTH-1:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest request.
  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL spurious_done: got done=1 expected no pending request (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(bus.result), 32'(e.res));
        chk("done_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(bus.busy), 32'(0));
  endtask

  // Issue one request and follow it to its done pulse, recording sh_s.
  task automatic do_op(input logic [WIDTH-1:0] op, input logic [CNTW-1:0] amt,
                       input logic [WIDTH-1:0] exp, input bit chk_seq);
    int n;
    bit got;
    logic [9:0] seq;
    wait_idle();
    bus.start   = 1'b1;
    bus.operand = op;
    bus.amount  = amt;
    sb.push_back('{exp, cyc + int'(amt) + 3});
    exp_done++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'(1));
    seq = '0;
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      seq = {seq[7:0], sh_s};
      n++;
      @(posedge clk); #1;
    end
    chk("done_seen", 32'(got), 32'(1));
    chk("op_cycles", 32'(n), 32'(int'(amt) + 2));
    chk("busy_in_done_cycle", 32'(bus.busy), 32'(0));
    if (chk_seq) chk("sh_s_seq", 32'(seq), 32'(10'b00_01_01_01_00));
  endtask

  initial begin
    vecs[0] = '{16'h8000, 4'd3,  16'hF000};
    vecs[1] = '{16'h7FFF, 4'd15, 16'h0000};
    vecs[2] = '{16'h8000, 4'd15, 16'hFFFF};
    vecs[3] = '{16'hA5A5, 4'd0,  16'hA5A5};
    vecs[4] = '{16'h4000, 4'd1,  16'h2000};
    vecs[5] = '{16'hC000, 4'd2,  16'hF000};
    vecs[6] = '{16'hFFFE, 4'd1,  16'hFFFF};
    vecs[7] = '{16'h8001, 4'd14, 16'hFFFE};
    vecs[8] = '{16'h5555, 4'd5,  16'h02AA};
    vecs[9] = '{16'h1234, 4'd4,  16'h0123};

    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.operand = '0;
    bus.amount  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(bus.busy),   32'(0));
    chk("rst_done",   32'(bus.done),   32'(0));
    chk("rst_result", 32'(bus.result), 32'(0));
    chk("rst_sh_rst", 32'(sh_rst),     32'(1));
    chk("rst_sh_s",   32'(sh_s),       32'(0));
    chk("rst_sh_dout",32'(sh_dout),    32'(0));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("sh_rst_released", 32'(sh_rst), 32'(0));

    // Table vectors, issued back-to-back (each starts in the prior done cycle).
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].op, vecs[i].amt, vecs[i].exp, i == 0);

    // start while busy: later request with other operand must be dropped.
    wait_idle();
    bus.start = 1'b1; bus.operand = 16'h1234; bus.amount = 4'd4;
    sb.push_back('{16'h0123, cyc + 4 + 3});
    exp_done++;
    @(posedge clk); #1;
    bus.operand = 16'hFFFF; bus.amount = 4'd1;
    repeat (3) begin @(posedge clk); #1; end
    bus.start = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.done && n < 20) begin @(posedge clk); #1; n++; end
      chk("ignored_start_done_seen", 32'(bus.done), 32'(1));
    end
    repeat (8) begin @(posedge clk); #1; end
    chk("ignored_start_no_extra", 32'(done_cnt), 32'(exp_done));
    chk("ignored_start_idle", 32'(bus.busy), 32'(0));

    // Reset in the second SHIFT cycle of an amount=8 operation.
    wait_idle();
    bus.start = 1'b1; bus.operand = 16'h8000; bus.amount = 4'd8;
    sb.push_back('{16'hFF80, cyc + 8 + 3});
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_abort_busy", 32'(bus.busy), 32'(1));
    rst = 1'b0;
    #1;
    chk("abort_busy",   32'(bus.busy),   32'(0));
    chk("abort_done",   32'(bus.done),   32'(0));
    chk("abort_result", 32'(bus.result), 32'(0));
    chk("abort_sh_rst", 32'(sh_rst),     32'(1));
    void'(sb.pop_front());
    @(posedge clk); #1;
    chk("abort_sh_dout", 32'(sh_dout), 32'(0));
    @(negedge clk) rst = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    chk("abort_no_done", 32'(done_cnt), 32'(exp_done));

    // Random back-to-back traffic against the signed-shift model.
    for (int i = 0; i < 12; i++) begin
      logic [WIDTH-1:0] op;
      logic [CNTW-1:0]  amt;
      op  = WIDTH'($urandom);
      amt = CNTW'($urandom_range(0, 15));
      do_op(op, amt, WIDTH'($signed(op) >>> amt), 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("final_done_count", 32'(done_cnt), 32'(exp_done));
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
